// File: rtl/router_in_port.sv
`default_nettype none
// ============================================================================
// Module   : router_in_port
// Purpose  : Router-side input channel fed by the NIC net_so/net_do stream.
//            Owns the even/odd polarity that selects the NIC virtual channel.
//            Each VC has its own DEPTH-entry FIFO. Ingress writes the VC that
//            matches the current polarity, and egress drains the opposite VC.
//            A packet therefore leaves one polarity phase after it arrives.
// Ports    : clk, reset         - clock, synchronous active-high reset
//            polarity           - VC phase, drives NIC net_polarity
//            in_si/in_ro/in_di  - upstream strobe / ready / data
//            out_so/out_ro/out_do - downstream strobe / ready / data
//            vc_err             - sticky: accepted packet VC bit != polarity
//            pkt_cnt            - saturating accepted-packet count
// Options  : ROUTER_IN_STATS_EN - when defined, pkt_cnt counts accepts;
//            otherwise pkt_cnt is tied to zero.
// Revision : 1.0 - initial release
// ============================================================================
module router_in_port #(
  parameter int DEPTH = 2,
  parameter int DW    = 64
) (
  input  logic          clk,
  input  logic          reset,
  output logic          polarity,
  input  logic          in_si,
  output logic          in_ro,
  input  logic [DW-1:0] in_di,
  output logic          out_so,
  input  logic          out_ro,
  output logic [DW-1:0] out_do,
  output logic          vc_err,
  output logic [15:0]   pkt_cnt
);

  localparam int c_AW = $clog2(DEPTH);
  localparam int c_CW = $clog2(DEPTH) + 1;
  localparam logic [c_CW-1:0] c_FULL = c_CW'(DEPTH);

  logic                r_pol;
  logic [DW-1:0]       r_mem  [2][DEPTH];
  logic [c_AW-1:0]     r_wptr [2];
  logic [c_AW-1:0]     r_rptr [2];
  logic [c_CW-1:0]     r_cnt  [2];
  logic                r_vc_err;

  logic                w_wvc;
  logic                w_rvc;
  logic                w_push;
  logic                w_pop;

  // Ingress and egress always address opposite VCs, so a FIFO never sees
  // a push and a pop in the same cycle.
  assign w_wvc    = r_pol;
  assign w_rvc    = ~r_pol;

  assign in_ro    = (r_cnt[w_wvc] != c_FULL);
  assign w_push   = in_si & in_ro;
  assign w_pop    = out_ro & (r_cnt[w_rvc] != '0);

  assign out_so   = w_pop;
  assign out_do   = w_pop ? r_mem[w_rvc][r_rptr[w_rvc]] : '0;
  assign polarity = r_pol;
  assign vc_err   = r_vc_err;

  // Control state: polarity, pointers, occupancy counts, sticky error.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pol    <= 1'b0;
      r_vc_err <= 1'b0;
      for (int v = 0; v < 2; v++) begin
        r_wptr[v] <= '0;
        r_rptr[v] <= '0;
        r_cnt[v]  <= '0;
      end
    end else begin
      r_pol <= ~r_pol;
      // The mismatched packet is still stored; only the flag records it.
      if (w_push && (in_di[DW-1] != r_pol)) begin
        r_vc_err <= 1'b1;
      end
      for (int v = 0; v < 2; v++) begin
        if (w_push && (w_wvc == 1'(v))) begin
          r_wptr[v] <= r_wptr[v] + 1'b1;
          r_cnt[v]  <= r_cnt[v] + 1'b1;
        end else if (w_pop && (w_rvc == 1'(v))) begin
          r_rptr[v] <= r_rptr[v] + 1'b1;
          r_cnt[v]  <= r_cnt[v] - 1'b1;
        end
      end
    end
  end

  // Packet storage carries no reset; occupancy is tracked by r_cnt alone.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[w_wvc][r_wptr[w_wvc]] <= in_di;
    end
  end

`ifdef ROUTER_IN_STATS_EN
  logic [15:0] r_pkt_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pkt_cnt <= 16'h0;
    end else if (w_push && (r_pkt_cnt != 16'hFFFF)) begin
      r_pkt_cnt <= r_pkt_cnt + 16'd1;
    end
  end

  assign pkt_cnt = r_pkt_cnt;
`else
  assign pkt_cnt = 16'h0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_router_in_port.sv
`default_nettype none
// ============================================================================
// Module   : tb_router_in_port
// Purpose  : Self-checking bench for router_in_port. A table of per-cycle
//            input/expected-output records walks through reset, single
//            packet, fill/back-pressure, simultaneous push/pop, held drain,
//            VC mismatch, mid-stream reset and back-to-back traffic. A queue
//            scoreboard per VC tracks accepted packets and checks every
//            packet the DUT emits against the oldest one expected.
// Revision : 1.0 - initial release
// ============================================================================
module tb_router_in_port;

  localparam int DEPTH = 2;
  localparam int DW    = 64;

  logic          clk = 1'b0;
  logic          reset;
  logic          polarity;
  logic          in_si;
  logic          in_ro;
  logic [DW-1:0] in_di;
  logic          out_so;
  logic          out_ro;
  logic [DW-1:0] out_do;
  logic          vc_err;
  logic [15:0]   pkt_cnt;

  always #5 clk = ~clk;

  router_in_port #(.DEPTH(DEPTH), .DW(DW)) dut (
    .clk      (clk),
    .reset    (reset),
    .polarity (polarity),
    .in_si    (in_si),
    .in_ro    (in_ro),
    .in_di    (in_di),
    .out_so   (out_so),
    .out_ro   (out_ro),
    .out_do   (out_do),
    .vc_err   (vc_err),
    .pkt_cnt  (pkt_cnt)
  );

  typedef struct {
    logic        rst;
    logic        si;
    logic [63:0] di;
    logic        ro;
    logic        pol;
    logic        iro;
    logic        so;
    logic [63:0] dout;
    logic        err;
    logic [15:0] cnt;
  } vec_t;

  vec_t        vecs[$];
  logic [63:0] sb_q0[$];
  logic [63:0] sb_q1[$];
  logic        pol_m;
  int          checks   = 0;
  int          failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic void add(input logic rst, input logic si, input logic [63:0] di,
                              input logic ro, input logic pol, input logic iro,
                              input logic so, input logic [63:0] dout,
                              input logic err, input logic [15:0] cnt);
    vec_t v;
    v.rst = rst; v.si = si; v.di = di; v.ro = ro; v.pol = pol;
    v.iro = iro; v.so = so; v.dout = dout; v.err = err; v.cnt = cnt;
    vecs.push_back(v);
  endfunction

  initial begin
    logic [63:0] odd;
    logic [63:0] exp_pkt;
    int          depth_rd;

    odd = 64'h8000_0000_0000_0000;

    reset  = 1'b1;
    in_si  = 1'b1;
    in_di  = odd | 64'hFF;
    out_ro = 1'b1;
    pol_m  = 1'b0;
    @(posedge clk); #1;

    //   rst si di            ro | pol iro so dout          err cnt
    // reset held with in_si=1: nothing may be written
    add(1, 1, odd | 64'hFF, 1,   0,  1,  0, 64'h0,        0,  0);
    add(1, 1, odd | 64'hFF, 1,   0,  1,  0, 64'h0,        0,  0);
    // single even packet, out next cycle
    add(0, 1, 64'hA5,       1,   0,  1,  0, 64'h0,        0,  0);
    add(0, 0, 64'h0,        1,   1,  1,  1, 64'hA5,       0,  1);
    add(0, 0, 64'h0,        1,   0,  1,  0, 64'h0,        0,  1);
    // fill FIFO[1] with out_ro=0; third offer refused
    add(0, 1, odd | 64'h01, 0,   1,  1,  0, 64'h0,        0,  1);
    add(0, 0, 64'h0,        0,   0,  1,  0, 64'h0,        0,  2);
    add(0, 1, odd | 64'h02, 0,   1,  1,  0, 64'h0,        0,  2);
    add(0, 0, 64'h0,        0,   0,  1,  0, 64'h0,        0,  3);
    add(0, 1, odd | 64'h03, 0,   1,  0,  0, 64'h0,        0,  3);
    add(0, 0, 64'h0,        1,   0,  1,  1, odd | 64'h01, 0,  3);
    add(0, 0, 64'h0,        1,   1,  1,  0, 64'h0,        0,  3);
    add(0, 0, 64'h0,        1,   0,  1,  1, odd | 64'h02, 0,  3);
    // FIFO[1] holds one, then push even while it pops
    add(0, 1, odd | 64'h55, 1,   1,  1,  0, 64'h0,        0,  3);
    add(0, 1, 64'h10,       1,   0,  1,  1, odd | 64'h55, 0,  4);
    add(0, 0, 64'h0,        1,   1,  1,  1, 64'h10,       0,  5);
    add(0, 0, 64'h0,        1,   0,  1,  0, 64'h0,        0,  5);
    // out_ro=0 in the drain cycle: next chance two cycles later
    add(0, 1, odd | 64'h66, 1,   1,  1,  0, 64'h0,        0,  5);
    add(0, 0, 64'h0,        0,   0,  1,  0, 64'h0,        0,  6);
    add(0, 0, 64'h0,        0,   1,  1,  0, 64'h0,        0,  6);
    add(0, 0, 64'h0,        1,   0,  1,  1, odd | 64'h66, 0,  6);
    add(0, 0, 64'h0,        1,   1,  1,  0, 64'h0,        0,  6);
    // odd-tagged packet in an even cycle: sticky error, still delivered
    add(0, 1, odd | 64'h07, 1,   0,  1,  0, 64'h0,        0,  6);
    add(0, 0, 64'h0,        1,   1,  1,  1, odd | 64'h07, 1,  7);
    add(0, 0, 64'h0,        1,   0,  1,  0, 64'h0,        1,  7);
    // buffer one per VC, then reset discards both
    add(0, 1, odd | 64'h99, 0,   1,  1,  0, 64'h0,        1,  7);
    add(0, 1, 64'h22,       0,   0,  1,  0, 64'h0,        1,  8);
    add(1, 1, odd | 64'hAA, 0,   1,  1,  0, 64'h0,        1,  9);
    add(0, 0, 64'h0,        1,   0,  1,  0, 64'h0,        0,  0);
    add(0, 0, 64'h0,        1,   1,  1,  0, 64'h0,        0,  0);
    add(0, 0, 64'h0,        1,   0,  1,  0, 64'h0,        0,  0);
    // back-to-back: one packet per cycle aggregate
    add(0, 1, odd | 64'hB1, 1,   1,  1,  0, 64'h0,        0,  0);
    add(0, 1, 64'hB2,       1,   0,  1,  1, odd | 64'hB1, 0,  1);
    add(0, 1, odd | 64'hB3, 1,   1,  1,  1, 64'hB2,       0,  2);
    add(0, 0, 64'h0,        1,   0,  1,  1, odd | 64'hB3, 0,  3);
    add(0, 0, 64'h0,        1,   1,  1,  0, 64'h0,        0,  3);

    for (int i = 0; i < vecs.size(); i++) begin
      reset  = vecs[i].rst;
      in_si  = vecs[i].si;
      in_di  = vecs[i].di;
      out_ro = vecs[i].ro;
      #3;

      chk($sformatf("r%0d_polarity", i), 64'(polarity), 64'(vecs[i].pol));
      chk($sformatf("r%0d_in_ro", i),    64'(in_ro),    64'(vecs[i].iro));
      chk($sformatf("r%0d_out_so", i),   64'(out_so),   64'(vecs[i].so));
      chk($sformatf("r%0d_out_do", i),   out_do,        vecs[i].dout);
      chk($sformatf("r%0d_vc_err", i),   64'(vc_err),   64'(vecs[i].err));
`ifdef ROUTER_IN_STATS_EN
      chk($sformatf("r%0d_pkt_cnt", i),  64'(pkt_cnt),  64'(vecs[i].cnt));
`else
      chk($sformatf("r%0d_pkt_cnt", i),  64'(pkt_cnt),  64'h0);
`endif

      // Scoreboard: egress drains the VC opposite the model polarity.
      depth_rd = pol_m ? sb_q0.size() : sb_q1.size();
      chk($sformatf("r%0d_sb_so", i), 64'(out_so), 64'(out_ro && (depth_rd != 0)));
      if (!vecs[i].rst) begin
        if (out_so) begin
          if (depth_rd == 0) begin
            checks++;
            failures++;
            $display("FAIL r%0d_sb_underflow actual=out_so=1 required=no packet pending", i);
          end else begin
            exp_pkt = pol_m ? sb_q0.pop_front() : sb_q1.pop_front();
            chk($sformatf("r%0d_sb_data", i), out_do, exp_pkt);
          end
        end
        if (in_si) begin
          if (!pol_m && (sb_q0.size() != DEPTH)) sb_q0.push_back(in_di);
          if (pol_m && (sb_q1.size() != DEPTH))  sb_q1.push_back(in_di);
        end
      end

      @(posedge clk); #1;
      if (vecs[i].rst) begin
        sb_q0.delete();
        sb_q1.delete();
        pol_m = 1'b0;
      end else begin
        pol_m = ~pol_m;
      end
    end

    chk("sb_drained", 64'(sb_q0.size() + sb_q1.size()), 64'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
